// File: rtl/tpg_pkg.sv
// Shared types and constants for the AGC time-pulse generator controller.
package tpg_pkg;

  localparam int unsigned TP_W = 12;

  localparam logic [TP_W-1:0] TP_T01 = 12'h001;
  localparam logic [TP_W-1:0] TP_T12 = 12'h800;

  typedef enum logic [1:0] {
    STBY  = 2'd0,
    PWRON = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } tpg_state_e;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [TP_W-1:0] v);
    return (v != '0) && ((v & (v - TP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/tpg_ring.sv
// One-hot T01..T12 rotate register; load-T01 beats clear, clear beats advance.
module tpg_ring
  import tpg_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clr,
  input  logic            adv,
  output logic [TP_W-1:0] tp
);

  logic [TP_W-1:0] ring;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring <= '0;
    end else if (load) begin
      ring <= TP_T01;
    end else if (clr) begin
      ring <= '0;
    end else if (adv) begin
      ring <= {ring[TP_W-2:0], ring[TP_W-1]};
    end
  end

  assign tp = ring;

endmodule

// File: rtl/tpg_control.sv
// Time-pulse generator controller: power-on, run, stop, standby and restart sequencing.
// Optional one-hot integrity check enabled by defining TPG_ONEHOT_CHK_EN.
module tpg_control
  import tpg_pkg::*;
#(
  parameter int unsigned PWRON_TICKS = 4,
  parameter int unsigned MCT_W       = 16
) (
  input  logic             CLOCK,
  input  logic             rst_,
  input  logic             adv,
  input  logic             stby,
  input  logic             mstp,
  input  logic             gojam,
  output logic [TP_W-1:0]  tp,
  output logic             tp_run,
  output logic             cycle_end,
  output logic [MCT_W-1:0] mct,
  output logic [1:0]       state,
  output logic             tpg_err
);

  localparam int unsigned TICK_W = 4;

  tpg_state_e        state_q;
  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] tick_inc;
  logic              jam;
  logic              at_t12;
  logic              pwron_done;
  logic              ring_load;
  logic              ring_clr;
  logic              ring_adv;
  logic              done;

  tpg_ring u_ring (
    .clk   (CLOCK),
    .rst_n (rst_),
    .load  (ring_load),
    .clr   (ring_clr),
    .adv   (ring_adv),
    .tp    (tp)
  );

  // Ring controls; gojam only acts once the pulse chain has been started.
  always_comb begin
    ring_load  = 1'b0;
    ring_clr   = 1'b0;
    ring_adv   = 1'b0;
    done       = 1'b0;
    jam        = gojam && (state_q == RUN || state_q == STOP);
    at_t12     = (tp == TP_T12);
    tick_inc   = tick + TICK_W'(1);
    pwron_done = (tick_inc == TICK_W'(PWRON_TICKS));
    case (state_q)
      STBY: ring_clr = 1'b1;
      PWRON: begin
        if (!stby && adv && pwron_done) ring_load = 1'b1;
        else                            ring_clr  = 1'b1;
      end
      RUN: begin
        if (jam) begin
          ring_load = 1'b1;
        end else if (adv) begin
          if (at_t12) begin
            done = 1'b1;
            if (stby || mstp) ring_clr  = 1'b1;
            else              ring_load = 1'b1;
          end else begin
            ring_adv = 1'b1;
          end
        end
      end
      STOP: begin
        if (jam || (!stby && adv && !mstp)) ring_load = 1'b1;
        else                                 ring_clr  = 1'b1;
      end
      default: ring_clr = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      state_q   <= STBY;
      tick      <= '0;
      tp_run    <= 1'b0;
      cycle_end <= 1'b0;
      mct       <= '0;
    end else begin
      cycle_end <= done;
      tp_run    <= ring_load || (state_q == RUN && !ring_clr);
      if (done) mct <= mct + MCT_W'(1);
      case (state_q)
        STBY: begin
          if (adv && !stby) begin
            state_q <= PWRON;
            tick    <= '0;
          end
        end
        PWRON: begin
          if (stby) begin
            state_q <= STBY;
          end else if (adv) begin
            tick <= tick_inc;
            if (pwron_done) state_q <= RUN;
          end
        end
        RUN: begin
          if (!jam && done) begin
            if (stby)      state_q <= STBY;
            else if (mstp) state_q <= STOP;
          end
        end
        STOP: begin
          if (jam)                state_q <= RUN;
          else if (stby)          state_q <= STBY;
          else if (adv && !mstp)  state_q <= RUN;
        end
        default: state_q <= STBY;
      endcase
    end
  end

  assign state = state_q;

`ifdef TPG_ONEHOT_CHK_EN
  logic err_c;

  always_comb begin
    err_c = 1'b0;
    if (state_q == RUN) err_c = !is_onehot(tp);
    else                err_c = (tp != '0);
  end

  // Sticky until reset or restart.
  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_)      tpg_err <= 1'b0;
    else if (gojam) tpg_err <= 1'b0;
    else if (err_c) tpg_err <= 1'b1;
  end
`else
  assign tpg_err = 1'b0;
`endif

endmodule

// File: tb/tb_tpg_control.sv
// Directed self-checking bench for tpg_control (MCT_W=4 to exercise counter wrap).
module tb_tpg_control;

  logic        CLOCK = 1'b0;
  logic        rst_;
  logic        adv, stby, mstp, gojam;
  logic [11:0] tp;
  logic        tp_run, cycle_end, tpg_err;
  logic [3:0]  mct;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulse  = 0;
  logic [3:0] exp_mct;

  tpg_control #(.PWRON_TICKS(4), .MCT_W(4)) u_dut (
    .CLOCK     (CLOCK),
    .rst_      (rst_),
    .adv       (adv),
    .stby      (stby),
    .mstp      (mstp),
    .gojam     (gojam),
    .tp        (tp),
    .tp_run    (tp_run),
    .cycle_end (cycle_end),
    .mct       (mct),
    .state     (state),
    .tpg_err   (tpg_err)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic a);
    adv = a;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  initial begin
    rst_ = 1'b0; adv = 1'b0; stby = 1'b0; mstp = 1'b0; gojam = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_tp", 32'(tp), 0);
    check("rst_run", 32'(tp_run), 0);
    check("rst_ce", 32'(cycle_end), 0);
    check("rst_mct", 32'(mct), 0);
    check("rst_err", 32'(tpg_err), 0);
    rst_ = 1'b1;

    // Power-up
    step(1'b0);
    check("stby_hold", 32'(state), 0);
    step(1'b1);
    check("to_pwron", 32'(state), 1);
    steps(3);
    check("pwron_wait", 32'(state), 1);
    check("pwron_tp", 32'(tp), 0);
    step(1'b1);
    check("to_run", 32'(state), 2);
    check("first_t01", 32'(tp), 12'h001);
    check("run_flag", 32'(tp_run), 1);
    steps(11);
    check("t12", 32'(tp), 12'h800);
    check("t12_ce", 32'(cycle_end), 0);
    step(1'b1);
    check("wrap_tp", 32'(tp), 12'h001);
    check("wrap_ce", 32'(cycle_end), 1);
    check("wrap_mct", 32'(mct), 1);
    step(1'b0);
    check("ce_pulse", 32'(cycle_end), 0);
    check("no_adv_hold", 32'(tp), 12'h001);

    // Stop and resume
    steps(4);
    check("t05", 32'(tp), 12'h010);
    mstp = 1'b1;
    steps(7);
    check("mstp_no_trunc", 32'(tp), 12'h800);
    check("mstp_run", 32'(state), 2);
    step(1'b1);
    check("stop_state", 32'(state), 3);
    check("stop_tp", 32'(tp), 0);
    check("stop_mct", 32'(mct), 2);
    check("stop_ce", 32'(cycle_end), 1);
    step(1'b1);
    check("stop_hold", 32'(state), 3);
    mstp = 1'b0;
    step(1'b1);
    check("resume_tp", 32'(tp), 12'h001);
    check("resume_state", 32'(state), 2);

    // Restart at T07
    steps(6);
    check("t07", 32'(tp), 12'h040);
    gojam = 1'b1;
    step(1'b1);
    check("jam_tp", 32'(tp), 12'h001);
    check("jam_ce", 32'(cycle_end), 0);
    check("jam_mct", 32'(mct), 2);
    step(1'b1);
    check("jam_hold", 32'(tp), 12'h001);
    gojam = 1'b0;
    step(1'b1);
    check("post_jam", 32'(tp), 12'h002);

    // Standby wins over stop at T12
    steps(10);
    check("t12_b", 32'(tp), 12'h800);
    stby = 1'b1; mstp = 1'b1;
    step(1'b1);
    check("stby_state", 32'(state), 0);
    check("stby_tp", 32'(tp), 0);
    check("stby_mct", 32'(mct), 3);
    check("stby_run", 32'(tp_run), 0);
    stby = 1'b0; mstp = 1'b0; gojam = 1'b1;
    step(1'b1);
    check("jam_ign_stby", 32'(state), 1);
    check("jam_ign_tp", 32'(tp), 0);
    gojam = 1'b0;

    // Standby aborts PWRON without adv
    steps(2);
    stby = 1'b1;
    step(1'b0);
    check("pwron_abort", 32'(state), 0);
    stby = 1'b0;

    // Counter wrap with 4-bit mct
    steps(5);
    check("rerun_tp", 32'(tp), 12'h001);
    exp_mct = 4'd3;
    n_pulse = 0;
    for (int c = 0; c < 16; c++) begin
      for (int p = 0; p < 12; p++) begin
        step(1'b1);
        n_pulse += int'(cycle_end);
      end
      exp_mct = exp_mct + 4'd1;
      check("wrap_cyc_mct", 32'(mct), 32'(exp_mct));
    end
    check("wrap_pulses", 32'(n_pulse), 16);
    check("wrap_final", 32'(mct), 3);

`ifdef TPG_ONEHOT_CHK_EN
    force u_dut.u_ring.ring = 12'h003;
    step(1'b0);
    check("err_set", 32'(tpg_err), 1);
    release u_dut.u_ring.ring;
    step(1'b0);
    check("err_sticky", 32'(tpg_err), 1);
`else
    check("err_tied", 32'(tpg_err), 0);
`endif

    // Asynchronous reset mid-cycle
    #2;
    rst_ = 1'b0;
    #1;
    check("arst_tp", 32'(tp), 0);
    check("arst_err", 32'(tpg_err), 0);
    check("arst_state", 32'(state), 0);
    check("arst_mct", 32'(mct), 0);
    check("arst_run", 32'(tp_run), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
